// File: rtl/display_timing_pkg.sv
// rtl/display_timing_pkg.sv - default raster timing, RGB565 pixel type and colour-bar helpers
package display_timing_pkg;

    localparam int H_ACTIVE_DEF   = 320;
    localparam int H_FP_DEF       = 20;
    localparam int H_SYNC_DEF     = 30;
    localparam int H_BP_DEF       = 30;
    localparam int V_ACTIVE_DEF   = 240;
    localparam int V_FP_DEF       = 4;
    localparam int V_SYNC_DEF     = 3;
    localparam int V_BP_DEF       = 15;
    localparam int PIXEL_BITS_DEF = 16;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam rgb565_t BAR_WHITE   = '{r: 5'h1F, g: 6'h3F, b: 5'h1F};
    localparam rgb565_t BAR_YELLOW  = '{r: 5'h1F, g: 6'h3F, b: 5'h00};
    localparam rgb565_t BAR_CYAN    = '{r: 5'h00, g: 6'h3F, b: 5'h1F};
    localparam rgb565_t BAR_GREEN   = '{r: 5'h00, g: 6'h3F, b: 5'h00};
    localparam rgb565_t BAR_MAGENTA = '{r: 5'h1F, g: 6'h00, b: 5'h1F};
    localparam rgb565_t BAR_RED     = '{r: 5'h1F, g: 6'h00, b: 5'h00};
    localparam rgb565_t BAR_BLUE    = '{r: 5'h00, g: 6'h00, b: 5'h1F};
    localparam rgb565_t BAR_BLACK   = '{r: 5'h00, g: 6'h00, b: 5'h00};

    function automatic logic [2:0] bar_index(input int unsigned h, input int unsigned h_active);
        return 3'((h * 8) / h_active);
    endfunction

    function automatic rgb565_t color_bar(input logic [2:0] bar);
        case (bar)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - pixel/line counters with enable and wrap, plus active and raw sync decode
module raster_counter
    import display_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int H_BITS   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_BITS   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    output logic [H_BITS-1:0] h_cnt_o,
    output logic [V_BITS-1:0] v_cnt_o,
    output logic              active_o,
    output logic              hsync_raw_o,
    output logic              vsync_raw_o,
    output logic              frame_wrap_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_ACT    = H_BITS'(H_ACTIVE);
    localparam logic [H_BITS-1:0] HS_FIRST = H_BITS'(H_ACTIVE + H_FP);
    localparam logic [H_BITS-1:0] HS_LAST  = H_BITS'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_ACT    = V_BITS'(V_ACTIVE);
    localparam logic [V_BITS-1:0] VS_FIRST = V_BITS'(V_ACTIVE + V_FP);
    localparam logic [V_BITS-1:0] VS_LAST  = V_BITS'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [H_BITS-1:0] h_q, h_d;
    logic [V_BITS-1:0] v_q, v_d;
    logic              line_end;

    assign line_end = (h_q == H_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en_i) begin
            if (line_end) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o      = h_q;
    assign v_cnt_o      = v_q;
    assign active_o     = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_raw_o  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    assign vsync_raw_o  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    assign frame_wrap_o = en_i && line_end && (v_q == V_LAST);

endmodule

// File: rtl/display_scanout.sv
// rtl/display_scanout.sv - raster scan-out: framebuffer read addressing and 2-stage sync/pixel pipeline
// TEST_PATTERN_EN adds test_sel, which swaps framebuffer pixels for 8 vertical colour bars.
module display_scanout
    import display_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIXEL_BITS = PIXEL_BITS_DEF,
    parameter int ADDR_BITS  = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    output logic [ADDR_BITS-1:0]  fb_rd_addr,
    input  logic [PIXEL_BITS-1:0] fb_rd_data,
`ifdef TEST_PATTERN_EN
    input  logic                  test_sel,
`endif
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [PIXEL_BITS-1:0] pixel,
    output logic                  frame_start
);

    localparam int H_BITS = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_BITS = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(H_ACTIVE * V_ACTIVE - 1);

    logic [H_BITS-1:0]     h_cnt;
    logic [V_BITS-1:0]     v_cnt;
    logic                  active, hsync_raw, vsync_raw, frame_wrap;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  s1_active_q, s1_hsync_q, s1_vsync_q, s1_first_q;
`ifdef TEST_PATTERN_EN
    logic [H_BITS-1:0]     s1_h_q;
`endif
    logic [PIXEL_BITS-1:0] cap_q, cap_d, fb_word;
    logic                  cap_vld_q, cap_vld_d;
    logic [PIXEL_BITS-1:0] pixel_q, pixel_d;
    logic                  de_q, hsync_q, vsync_q, fs_q, fs_d;

    raster_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_BITS(H_BITS), .V_BITS(V_BITS)
    ) u_raster (
        .clk          (clk),
        .rst          (rst),
        .en_i         (pix_en),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .active_o     (active),
        .hsync_raw_o  (hsync_raw),
        .vsync_raw_o  (vsync_raw),
        .frame_wrap_o (frame_wrap)
    );

    always_comb begin
        addr_d = addr_q;
        if (pix_en) begin
            if (frame_wrap) begin
                addr_d = '0;
            end else if (active) begin
                addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            end
        end

        // Read data belongs to the pixel in stage 1 only on the cycle after it was loaded;
        // on the first stalled edge it is captured so a free-running RAM cannot overtake it.
        cap_d     = cap_q;
        cap_vld_d = cap_vld_q;
        if (pix_en) begin
            cap_vld_d = 1'b0;
        end else if (!cap_vld_q) begin
            cap_d     = fb_rd_data;
            cap_vld_d = 1'b1;
        end
        fb_word = cap_vld_q ? cap_q : fb_rd_data;

        pixel_d = s1_active_q ? fb_word : '0;
`ifdef TEST_PATTERN_EN
        if (test_sel && s1_active_q) begin
            pixel_d = PIXEL_BITS'(color_bar(bar_index(32'(s1_h_q), H_ACTIVE)));
        end
`endif
        fs_d = pix_en && s1_first_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q      <= '0;
            s1_active_q <= 1'b0;
            s1_hsync_q  <= 1'b1;
            s1_vsync_q  <= 1'b1;
            s1_first_q  <= 1'b0;
`ifdef TEST_PATTERN_EN
            s1_h_q      <= '0;
`endif
            cap_q       <= '0;
            cap_vld_q   <= 1'b0;
            pixel_q     <= '0;
            de_q        <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            fs_q        <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            fs_q      <= fs_d;
            if (pix_en) begin
                s1_active_q <= active;
                s1_hsync_q  <= hsync_raw;
                s1_vsync_q  <= vsync_raw;
                s1_first_q  <= (h_cnt == '0) && (v_cnt == '0);
`ifdef TEST_PATTERN_EN
                s1_h_q      <= h_cnt;
`endif
                pixel_q     <= pixel_d;
                de_q        <= s1_active_q;
                hsync_q     <= s1_hsync_q;
                vsync_q     <= s1_vsync_q;
            end
        end
    end

    assign fb_rd_addr  = addr_q;
    assign pixel       = pixel_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scanout.sv
// tb/tb_display_scanout.sv - scoreboard bench for display_scanout with default line timing and a 4-line frame
module tb_display_scanout;

    localparam int HA = 320, HFP = 20, HS = 30, HBP = 30;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = 400, VT = 8, AB = 11, FRAME = 3200;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] px;
    } out_t;

    logic          clk = 1'b0, rst = 1'b0, pix_en = 1'b0, test_sel = 1'b0;
    logic [AB-1:0] fb_rd_addr;
    logic [15:0]   fb_rd_data = '0;
    logic          hsync, vsync, de, frame_start;
    logic [15:0]   pixel;

    display_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIXEL_BITS(16), .ADDR_BITS(AB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .fb_rd_addr  (fb_rd_addr),
        .fb_rd_data  (fb_rd_data),
`ifdef TEST_PATTERN_EN
        .test_sel    (test_sel),
`endif
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pixel       (pixel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    out_t        sb[$];
    out_t        rst_out, last, mon_got, mon_exp;
    logic [15:0] bars[8];
    int          n_tests = 0, n_fail = 0;
    int          m_h = 0, m_v = 0, cyc = 0;
    int          de_acc = 0, fs_prev = 0, fs_interval = 0, fs_de = 0;
    bit          fs_have = 0;
    logic        mon_on = 1'b0, en_edge = 1'b0;

    function automatic logic [15:0] fbf(input int a);
        return 16'(a) ^ 16'hA5C3;
    endfunction

    function automatic int exp_addr(input int h, input int v);
        if (v >= VA) return 0;
        if (h < HA) return v * HA + h;
        return ((v + 1) * HA) % (HA * VA);
    endfunction

    function automatic out_t exp_out(input int h, input int v, input logic ts);
        out_t e;
        logic act;
        act  = (h < HA) && (v < VA);
        e.de = act;
        e.hs = !(h >= 340 && h <= 369);
        e.vs = !(v >= 5 && v <= 6);
        e.fs = (h == 0) && (v == 0);
        e.px = !act ? 16'h0 : (ts ? bars[h / 40] : fbf(v * HA + h));
        return e;
    endfunction

    // Free-running synchronous framebuffer RAM: data one clock after the address.
    always @(posedge clk) fb_rd_data <= fbf(int'(fb_rd_addr));
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) en_edge <= pix_en && rst;

    always @(negedge clk) begin
        if (mon_on) begin
            mon_got = {de, hsync, vsync, frame_start, pixel};
            n_tests++;
            if (en_edge) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow at cyc %0d", cyc);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_fail++;
                        $display("FAIL out cyc %0d got de=%b hs=%b vs=%b fs=%b px=%h required de=%b hs=%b vs=%b fs=%b px=%h",
                                 cyc, mon_got.de, mon_got.hs, mon_got.vs, mon_got.fs, mon_got.px,
                                 mon_exp.de, mon_exp.hs, mon_exp.vs, mon_exp.fs, mon_exp.px);
                    end
                end
                if (mon_got.fs) begin
                    if (fs_have) begin
                        fs_interval = cyc - fs_prev;
                        fs_de       = de_acc;
                    end
                    fs_prev = cyc;
                    fs_have = 1;
                    de_acc  = 0;
                end
                if (mon_got.de) de_acc++;
            end else begin
                mon_exp    = last;
                mon_exp.fs = 1'b0;
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc %0d got de=%b hs=%b vs=%b fs=%b px=%h required de=%b hs=%b vs=%b fs=0 px=%h",
                             cyc, mon_got.de, mon_got.hs, mon_got.vs, mon_got.fs, mon_got.px,
                             mon_exp.de, mon_exp.hs, mon_exp.vs, mon_exp.px);
                end
            end
            last = mon_got;
        end
    end

    task automatic chk(input string name, input int got, input int req);
        n_tests++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic tick(input logic en);
        pix_en = en;
        if (en) begin
            n_tests++;
            if (int'(fb_rd_addr) != exp_addr(m_h, m_v)) begin
                n_fail++;
                $display("FAIL fb_rd_addr h=%0d v=%0d got %0d required %0d",
                         m_h, m_v, fb_rd_addr, exp_addr(m_h, m_v));
            end
            sb.push_back(exp_out(m_h, m_v, test_sel));
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v++;
                if (m_v == VT) m_v = 0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int hold);
        rst    = 1'b0;
        pix_en = 1'b1;
        mon_on = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #2;
        end
        chk("rst_de", int'(de), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_addr", int'(fb_rd_addr), 0);
        sb.delete();
        sb.push_back(rst_out);
        last        = rst_out;
        m_h         = 0;
        m_v         = 0;
        de_acc      = 0;
        fs_have     = 0;
        fs_interval = 0;
        fs_de       = 0;
        rst         = 1'b1;
        mon_on      = 1'b1;
    endtask

    initial begin
        rst_out = {1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        bars    = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

        do_reset(3);
        repeat (2 * FRAME + 4) tick(1'b1);
        chk("frame_interval_cont", fs_interval, FRAME);
        chk("frame_de_cont", fs_de, HA * VA);

        do_reset(1);
        repeat (2 * FRAME + 4) begin
            tick(1'b1);
            tick(1'b0);
        end
        chk("frame_interval_toggle", fs_interval, 2 * FRAME);
        chk("frame_de_toggle", fs_de, HA * VA);

        do_reset(1);
        repeat (2 * HT + 50) tick(1'b1);
        do_reset(1);
        repeat (HT + 8) tick(1'b1);

`ifdef TEST_PATTERN_EN
        // Switch test_sel only while the in-flight pixels are blanking.
        while (m_h != 330) tick(1'b1);
        test_sel = 1'b1;
        repeat (HT) tick(1'b1);
        test_sel = 1'b0;
        repeat (4) tick(1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
